// File: rtl/spi_master_pkg.sv
// Purpose: shared constants and types for the SPI master datapath (shifter, TX/RX FIFOs).
// Latency: n/a (declarations only).
// Backpressure: n/a.
package spi_master_pkg;

    localparam int SPI_DATA_WIDTH      = 32;
    localparam int SPI_FIFO_LOG_DEPTH  = 3;

    typedef logic [SPI_DATA_WIDTH-1:0] spi_word_t;

endpackage

// File: rtl/spi_fifo_mem.sv
// Purpose: depth x width register array, one synchronous write port, one async read port.
// Latency: write visible on rd_data the cycle after the write edge; read is combinational.
// Backpressure: none; the owning FIFO decides when writes are allowed.
module spi_fifo_mem
    import spi_master_pkg::*;
#(
    parameter int WIDTH  = SPI_DATA_WIDTH,
    parameter int ADDR_W = SPI_FIFO_LOG_DEPTH
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WIDTH-1:0]  wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [WIDTH-1:0]  rd_data
);

    logic [WIDTH-1:0] mem [2**ADDR_W];

    // Storage is intentionally never reset; only the pointers define validity.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/spi_master_rx_fifo.sv
// Purpose: RX word buffer between SPI receive shifter and read side, first-word fall-through.
// Latency: word pushed at edge N appears on data_o/valid_o after edge N (1 cycle).
// Backpressure: ready_o drops when full (from registered count only); full refuses pushes even with a same-cycle pop.
module spi_master_rx_fifo
    import spi_master_pkg::*;
#(
    parameter int DATA_WIDTH       = SPI_DATA_WIDTH,
    parameter int LOG_BUFFER_DEPTH = SPI_FIFO_LOG_DEPTH,
    parameter int ALMOST_FULL_LVL  = 6
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      clr_i,
    input  logic [DATA_WIDTH-1:0]     data_i,
    input  logic                      valid_i,
    output logic                      ready_o,
    output logic [DATA_WIDTH-1:0]     data_o,
    output logic                      valid_o,
    input  logic                      ready_i,
    output logic [LOG_BUFFER_DEPTH:0] elements_o,
    output logic                      almost_full_o
);

    localparam logic [LOG_BUFFER_DEPTH:0] DEPTH_CNT =
        (LOG_BUFFER_DEPTH+1)'(2**LOG_BUFFER_DEPTH);
    localparam logic [LOG_BUFFER_DEPTH:0] AF_LVL =
        (LOG_BUFFER_DEPTH+1)'(ALMOST_FULL_LVL);

    logic [LOG_BUFFER_DEPTH-1:0] wr_ptr;
    logic [LOG_BUFFER_DEPTH-1:0] rd_ptr;
    logic [LOG_BUFFER_DEPTH:0]   count;
    logic [LOG_BUFFER_DEPTH:0]   count_next;
    logic                        almost_full_q;
    logic                        push;
    logic                        pop;
    logic                        wr_en;

    // Handshakes only depend on registered count, so no valid->ready or ready->ready paths exist.
    assign ready_o = (count != DEPTH_CNT);
    assign valid_o = (count != '0);
    assign push    = valid_i && ready_o;
    assign pop     = valid_o && ready_i;
    // A flushed or reset cycle must not leave a stray write behind.
    assign wr_en   = push && !clr_i && !rst;

    // Next fill level; the almost-full flag is registered from this so it tracks count with no lag.
    always_comb begin
        count_next = count;
        if (clr_i) begin
            count_next = '0;
        end else if (push && !pop) begin
            count_next = count + 1'b1;
        end else if (pop && !push) begin
            count_next = count - 1'b1;
        end
    end

    // Pointer, count and status registers; rst beats clr_i, clr_i beats push/pop.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            count         <= '0;
            almost_full_q <= 1'b0;
        end else begin
            if (clr_i) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + 1'b1;
                if (pop)  rd_ptr <= rd_ptr + 1'b1;
            end
            count         <= count_next;
            almost_full_q <= (count_next >= AF_LVL);
        end
    end

    spi_fifo_mem #(
        .WIDTH  (DATA_WIDTH),
        .ADDR_W (LOG_BUFFER_DEPTH)
    ) u_mem (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_addr (wr_ptr),
        .wr_data (data_i),
        .rd_addr (rd_ptr),
        .rd_data (data_o)
    );

    assign elements_o    = count;
    assign almost_full_o = almost_full_q;

endmodule

// File: doc/spi_master_rx_fifo.md
Name: spi_master_rx_fifo

Overview:
- Receive-side word buffer that sits directly downstream of the SPI master receive shifter.
- It accepts 32-bit words from the shifter's data/data_valid/data_ready handshake.
- It presents them first-word-fall-through to the register/AXI read side.
- It supplies fill level and almost-full status to the control block.
- Backpressure, not dropping, is the flow-control mechanism: when the buffer is full the shifter stalls its SPI clock.

Parameters:
- DATA_WIDTH, 32, word width; matches the shifter output.
- LOG_BUFFER_DEPTH, 3, log2 of depth; depth is 8 words. Must be >= 1, so depth is always a power of two.
- ALMOST_FULL_LVL, 6, fill level at or above which almost_full_o asserts. Legal range is 1..depth.

Ports:
- clk  in  1  Block clock; single clock domain.
- rst  in  1  Synchronous, active-high reset.
- clr_i  in  1  Synchronous flush of buffer contents.
- data_i  in  DATA_WIDTH  Write data from the receive shifter.
- valid_i  in  1  Write request from the receive shifter (its data_valid).
- ready_o  out  1  Space available; drives the shifter's data_ready.
- data_o  out  DATA_WIDTH  Head-of-buffer word.
- valid_o  out  1  Buffer non-empty.
- ready_i  in  1  Read-side consume strobe.
- elements_o  out  LOG_BUFFER_DEPTH+1  Current fill level, 0..depth.
- almost_full_o  out  1  Asserted when elements_o >= ALMOST_FULL_LVL.

Behaviour:
- Reset
  - Synchronous, active-high reset on clk: when rst=1 at a rising edge, write pointer, read pointer and element count go to 0.
  - Outputs after reset: ready_o=1, valid_o=0, elements_o=0, almost_full_o=0.
  - data_o after reset is the content of location 0; it is don't-care while valid_o=0.
  - Storage array contents are not reset.
  - Reset mid-transfer discards all words.
- Push
  - A push occurs when valid_i && ready_o at a rising edge.
  - data_i is written at the write pointer, the write pointer increments modulo depth, and the count increments.
- Pop
  - A pop occurs when valid_o && ready_i at a rising edge.
  - The read pointer increments modulo depth and the count decrements.
  - ready_i while empty is ignored: no pointer or count change.
- Flow control
  - ready_o = (count != depth). It is a function of registered state only, with no combinational path from valid_i or ready_i.
  - This is mandatory because the shifter derives data_valid and its next state combinationally from data_ready.
  - When full, a push is refused even if a pop occurs in the same cycle. ready_o rises the cycle after the pop.
- Read side (first-word fall-through)
  - valid_o = (count != 0).
  - data_o = mem[read pointer], combinational from registered state.
  - A word pushed at edge N is visible on data_o/valid_o after edge N, so read latency is 1 cycle.
- Simultaneous events
  - Push and pop in the same cycle (0 < count < depth): both pointers advance and the count is unchanged.
  - Push and pop in the same cycle when count=0: only the push takes effect, since valid_o=0.
- Flush
  - clr_i at an edge zeroes both pointers and the count.
  - clr_i has priority over a simultaneous push or pop; that push is lost and that pop is not performed.
  - rst has priority over clr_i.
- Wrap-around
  - Pointers are LOG_BUFFER_DEPTH bits wide and wrap naturally.
  - Full and empty are decided by the separate count register, not by pointer comparison.
- Status
  - elements_o is the count register.
  - almost_full_o is a registered-compare output: it reflects the count after the edge, with no extra delay cycle.
- Error conditions: none. Overflow is impossible by construction, and underflow is ignored.

Decomposition:
- Shared package spi_master_pkg holds:
  - SPI_DATA_WIDTH = 32.
  - the default depth constant.
  - the word typedef spi_word_t (logic [31:0]).
- The shifter, TX FIFO and this block all use the package.
- A single sub-module is natural: spi_fifo_mem, a depth x width register array with one write port and one asynchronous read port. It is shared with the TX-side FIFO.
- Pointer, count and handshake logic stay in the top module.

Test Plan:
- Reset then idle, rst held 2 cycles and released:
  - valid_o=0, ready_o=1, elements_o=0, almost_full_o=0.
  - ready_i pulses cause no change.
- Single word, push 0xDEADBEEF:
  - the next cycle shows valid_o=1, data_o=0xDEADBEEF, elements_o=1.
  - a pop returns elements_o=0 and valid_o=0.
- Fill to full, 8 back-to-back pushes 0x0..0x7 with ready_i=0:
  - almost_full_o rises after the 6th push.
  - ready_o=0 after the 8th push; a 9th push (0xFF) is refused.
  - draining yields 0x0..0x7 in order.
- Full with simultaneous push and pop:
  - at count=8, valid_i=1 and ready_i=1 for one cycle → count=7, pushed word discarded, ready_o=1 the next cycle.
- Wrap-around and concurrency:
  - 20 words streamed with a random ready_i pattern, read order matches write order across pointer wrap.
  - push+pop cycles hold the count constant.
- Flush and reset mid-operation:
  - with 5 words stored, clr_i together with a push and a pop → elements_o=0, valid_o=0.
  - repeat with rst instead; the next push 0xA5A5A5A5 is read first.
